// File: rtl/fanin_merge_if.sv
// Handshake bundle between NUM_IN producers, the fan-in merge and a single consumer.
// The master side drives producer traffic and consumer ready; the slave side is the merge.
interface fanin_merge_if #(
    parameter int NUM_IN     = 6,
    parameter int DATA_WIDTH = 17
);
    logic [NUM_IN-1:0]            cfg_en;
    logic [NUM_IN-1:0]            in_valid;
    logic [NUM_IN*DATA_WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]            in_ready;
    logic                         out_valid;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [2:0]                   out_src;
    logic                         out_ready;

    modport master (
        output cfg_en,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_src
    );

    modport slave (
        input  cfg_en,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_src
    );
endinterface

// File: rtl/fanin_merge.sv
// Round-robin merge of NUM_IN valid/ready producers into one stream through a
// 2-entry FIFO that tags each payload with the index of the channel it came from.
module fanin_merge #(
    parameter int NUM_IN     = 6,
    parameter int DATA_WIDTH = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    fanin_merge_if.slave bus
);
    localparam int SRC_W = 3;

    // First requesting channel at or after ptr, wrapping; MSB flags that one was found.
    function automatic logic [SRC_W:0] rr_pick(
        input logic [NUM_IN-1:0] req,
        input logic [SRC_W-1:0]  ptr
    );
        logic [SRC_W:0] res;
        int             sum;
        int             idx;
        res = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            sum = int'(ptr) + k;
            idx = (sum >= NUM_IN) ? (sum - NUM_IN) : sum;
            res = req[idx] ? {1'b1, SRC_W'(idx)} : res;
        end
        return res;
    endfunction

    function automatic logic [SRC_W-1:0] ptr_after(input logic [SRC_W-1:0] g);
        return (g == SRC_W'(NUM_IN - 1)) ? 3'd0 : (g + 3'd1);
    endfunction

    logic [SRC_W-1:0]      rr_ptr_r;
    logic [1:0]            count_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] data0_r;
    logic [DATA_WIDTH-1:0] data1_r;
    logic [SRC_W-1:0]      src0_r;
    logic [SRC_W-1:0]      src1_r;

    logic [NUM_IN-1:0]     req_s;
    logic [NUM_IN-1:0]     grant_s;
    logic [SRC_W:0]        pick_s;
    logic                  push_s;
    logic                  pop_s;
    logic [SRC_W-1:0]      grant_idx_s;
    logic [DATA_WIDTH-1:0] sel_data_s;

    // Arbitration: a grant is offered only with room in the FIFO and no flush or reset.
    always_comb begin
        req_s       = bus.cfg_en & bus.in_valid;
        pick_s      = rr_pick(req_s, rr_ptr_r);
        grant_idx_s = pick_s[SRC_W-1:0];
        grant_s     = '0;
        push_s      = 1'b0;
        if (rst_n && !flush && (count_r != 2'd2) && pick_s[SRC_W]) begin
            grant_s[grant_idx_s] = 1'b1;
            push_s               = 1'b1;
        end else begin
            grant_s = '0;
            push_s  = 1'b0;
        end
    end

    // Payload mux for the granted channel.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_s[i]) begin
                sel_data_s = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    assign pop_s = out_valid_r & bus.out_ready;

    // Round-robin pointer: moves past the granted channel only when a push happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= 3'd0;
        end else if (flush) begin
            rr_ptr_r <= 3'd0;
        end else if (push_s) begin
            rr_ptr_r <= ptr_after(grant_idx_s);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Occupancy and head-valid; flush wins over a simultaneous pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r     <= 2'd0;
            out_valid_r <= 1'b0;
        end else if (flush) begin
            count_r     <= 2'd0;
            out_valid_r <= 1'b0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    count_r     <= count_r + 2'd1;
                    out_valid_r <= 1'b1;
                end
                2'b01: begin
                    count_r     <= count_r - 2'd1;
                    out_valid_r <= (count_r == 2'd2);
                end
                default: begin
                    count_r     <= count_r;
                    out_valid_r <= out_valid_r;
                end
            endcase
        end
    end

    // Shift-style storage: entry 0 is always the head, so outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data0_r <= '0;
            src0_r  <= 3'd0;
            data1_r <= '0;
            src1_r  <= 3'd0;
        end else if (flush) begin
            data0_r <= data0_r;
            src0_r  <= src0_r;
            data1_r <= data1_r;
            src1_r  <= src1_r;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        data0_r <= sel_data_s;
                        src0_r  <= grant_idx_s;
                        data1_r <= data1_r;
                        src1_r  <= src1_r;
                    end else begin
                        data0_r <= data0_r;
                        src0_r  <= src0_r;
                        data1_r <= sel_data_s;
                        src1_r  <= grant_idx_s;
                    end
                end
                2'b01: begin
                    data0_r <= data1_r;
                    src0_r  <= src1_r;
                    data1_r <= data1_r;
                    src1_r  <= src1_r;
                end
                // Push with pop only happens at count 1: the new entry becomes the head.
                2'b11: begin
                    data0_r <= (count_r == 2'd1) ? sel_data_s : data1_r;
                    src0_r  <= (count_r == 2'd1) ? grant_idx_s : src1_r;
                    data1_r <= sel_data_s;
                    src1_r  <= grant_idx_s;
                end
                default: begin
                    data0_r <= data0_r;
                    src0_r  <= src0_r;
                    data1_r <= data1_r;
                    src1_r  <= src1_r;
                end
            endcase
        end
    end

    assign bus.in_ready  = grant_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = data0_r;
    assign bus.out_src   = src0_r;

endmodule

// File: doc/fanin_merge.md
FANIN_MERGE -- requirements
Module: fanin_merge

Interface
REQ-001 SHALL have parameter NUM_IN, default 6, number of producer channels (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 17, payload width per channel.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port flush, input, 1, synchronous clear of buffer and arbiter state.
REQ-006 SHALL have port cfg_en, input, NUM_IN, per-channel enable; 0 = channel ignored.
REQ-007 SHALL have port in_valid, input, NUM_IN, per-channel valid.
REQ-008 SHALL have port in_data, input, NUM_IN*DATA_WIDTH, channel i payload in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port in_ready, output, NUM_IN, per-channel ready; at most one bit high per cycle.
REQ-010 SHALL have port out_valid, output, 1, head of output buffer valid.
REQ-011 SHALL have port out_data, output, DATA_WIDTH, head payload.
REQ-012 SHALL have port out_src, output, 3, channel index that produced the head payload.
REQ-013 SHALL have port out_ready, input, 1, consumer ready.

Function
REQ-014 SHALL contain a 2-entry FIFO (payload + source index) with a count register of 0..2.
REQ-015 SHALL define req[i] = cfg_en[i] & in_valid[i].
REQ-016 SHALL grant exactly one requesting channel per cycle when count < 2 and flush = 0; no grant otherwise.
REQ-017 SHALL select the grant round-robin: the first req[i] scanning from rr_ptr upward, wrapping modulo NUM_IN.
REQ-018 SHALL drive in_ready[i] = 1 only for the granted channel; in_ready is combinational from req, count, rr_ptr and flush.
REQ-019 SHALL push the granted channel's payload and index into the FIFO at the clock edge where in_valid[g] & in_ready[g].
REQ-020 SHALL update rr_ptr to (g+1) mod NUM_IN on a push; rr_ptr SHALL hold when there is no push.
REQ-021 SHALL pop the head at the edge where out_valid & out_ready.
REQ-022 SHALL assert out_valid iff count > 0; out_data and out_src SHALL come from the head entry.
REQ-023 Latency: payload accepted at edge N SHALL appear on out_valid/out_data in cycle N+1 when the FIFO was empty.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-025 When count = 2 SHALL not grant, even if out_ready = 1 in the same cycle (no combinational out_ready -> in_ready path).
REQ-026 When cfg_en[i] = 0, in_ready[i] SHALL be 0 and channel i SHALL be skipped by the scan; cfg_en may change on any cycle and takes effect on that cycle's arbitration.
REQ-027 flush = 1 SHALL force in_ready = 0; at the next edge it SHALL set count to 0 and rr_ptr to 0. Flush SHALL take priority over a simultaneous pop.
REQ-028 SHALL not drop or duplicate a payload: every in handshake produces exactly one out handshake unless flushed.

Reset
REQ-029 On rst_n = 0 SHALL immediately set count = 0, rr_ptr = 0, out_valid = 0, in_ready = 0, out_data = 0, out_src = 0, independent of clk.
REQ-030 After rst_n deasserts SHALL arbitrate on the first rising edge with rr_ptr = 0.

Verification
REQ-031 Single source: cfg_en = 6'b000100, in_valid[2] = 1, data 0x00A5, out_ready = 1 -> in_ready = 6'b000100; out_valid next cycle, out_data = 0x00A5, out_src = 2; one output per cycle.
REQ-032 Fairness: all 6 enabled and valid, out_ready = 1 -> grant order 0,1,2,3,4,5,0; out_src follows the same sequence.
REQ-033 Backpressure: out_ready = 0, channels 0 and 1 valid -> two pushes (src 0, then src 1), then in_ready = 0; raise out_ready -> outputs src 0 then src 1, with no grant in the first cycle it is raised.
REQ-034 Disable: cfg_en[3] = 0 with in_valid[3] = 1 for 20 cycles -> in_ready[3] never 1 and src 3 never output.
REQ-035 Flush with count = 2 and out_ready = 1 -> next cycle count = 0, out_valid = 0, rr_ptr = 0; the next grant goes to the lowest valid enabled channel.
REQ-036 Asynchronous reset asserted mid-stream between edges -> out_valid and in_ready drop to 0 without waiting for a clock edge; there is no output until a new input is accepted.
